// File: rtl/serial_arith_pkg.sv
// Shared definitions for the digit-serial arithmetic blocks: FSM state
// encoding and the digits-per-operation helper.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// Combinational DIGIT-bit ripple slice built from full-adder cells; also
// exposes the carry into its top bit so the caller can form signed overflow.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per
// clock, LSB digit first, through one ripple slice and a registered carry.
module serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // state  | meaning
    // IDLE   | waiting for start
    // RUN    | one digit per edge, cnt = digit index
    // DONE   | result just written; done pulse, start accepted back-to-back

    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t state, state_nxt;
    logic   load, step, last;

    logic [WIDTH-1:0] a_sh, b_sh, ps, ps_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] sl_s;
    logic             sl_co, sl_cm;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = (cnt == CW'(NDIG - 1));
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    load      = 1'b1;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    load      = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    digit_adder #(.DIGIT(DIGIT)) u_slice (
        .a     (a_sh[DIGIT-1:0]),
        .b     (b_sh[DIGIT-1:0]),
        .ci    (carry),
        .s     (sl_s),
        .co    (sl_co),
        .c_msb (sl_cm)
    );

    // Slice result enters at the top; after NDIG steps the full sum is aligned.
    assign ps_nxt = (ps >> DIGIT) | (WIDTH'(sl_s) << (WIDTH - DIGIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh  <= '0;
            b_sh  <= '0;
            ps    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b ^ {WIDTH{sub}};
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
        end else if (step) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            ps    <= ps_nxt;
            carry <= sl_co;
            if (last) begin
                cnt  <= '0;
                sum  <= ps_nxt;
                cout <= sl_co;
                ovf  <= sl_cm ^ sl_co;
            end else begin
                cnt  <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench: four serial_addsub instances (W=8, D=1/2/4/8) sharing
// stimulus, checked against an arithmetic reference model.
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       reset, start, sub, cin;
    logic [7:0] a, b;

    logic       busy_v [4];
    logic       done_v [4];
    logic       cout_v [4];
    logic       ovf_v  [4];
    logic [7:0] sum_v  [4];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) dut_d1 (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));
    serial_addsub #(.WIDTH(8), .DIGIT(2)) dut_d2 (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));
    serial_addsub #(.WIDTH(8), .DIGIT(4)) dut_d4 (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));
    serial_addsub #(.WIDTH(8), .DIGIT(8)) dut_d8 (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_v[3]), .done(done_v[3]), .sum(sum_v[3]), .cout(cout_v[3]), .ovf(ovf_v[3]));

    // Reference: {cout, ovf, sum} from plain 9-bit arithmetic.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic s, input logic c);
        logic [7:0] yy;
        logic [8:0] full;
        logic       v;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {8'd0, (s ? 1'b1 : c)};
        v    = (x[7] == yy[7]) && (full[7] != x[7]);
        return {full[8], v, full[7:0]};
    endfunction

    function automatic logic [9:0] result(input int i);
        return {cout_v[i], ovf_v[i], sum_v[i]};
    endfunction

    // Caller is #1 after an edge; the next edge samples start.
    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic s, input logic c);
        a = x; b = y; sub = s; cin = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic quiesce();
        bit quiet;
        quiet = 0;
        for (int k = 0; k < 30; k++) begin
            if (!busy_v[0] && !busy_v[1] && !busy_v[2] && !busy_v[3] &&
                !done_v[0] && !done_v[1] && !done_v[2] && !done_v[3]) begin
                quiet = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!quiet) begin
            vectors++; errors++;
            $display("FAIL quiesce: instances still active after 30 cycles");
        end
    endtask

    task automatic wait_done(input int i);
        bit seen;
        seen = 0;
        for (int k = 0; k < 16; k++) begin
            if (done_v[i]) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_done[%0d]: done=0 required 1 within 16 cycles", i);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({busy_v[i], done_v[i], result(i)} !== 12'h000) begin
                errors++;
                $display("FAIL reset[%0d]: busy=%b done=%b res=%h required all 0",
                         i, busy_v[i], done_v[i], result(i));
            end
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_latency();
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            vectors++;
            if ({busy_v[0], done_v[0]} !== {(k <= 7), (k == 8)}) begin
                errors++;
                $display("FAIL latency k=%0d: busy/done=%b%b required %b%b",
                         k, busy_v[0], done_v[0], (k <= 7), (k == 8));
            end
            if (k == 8) begin
                vectors++;
                if (result(0) !== 10'b1_0_00000000) begin
                    errors++;
                    $display("FAIL add_ff_01: res=%h required %h", result(0), 10'b1_0_00000000);
                end
            end
        end
        quiesce();
    endtask

    task automatic test_sub_d1();
        issue(8'h80, 8'h01, 1'b1, 1'b0);
        wait_done(0);
        vectors++;
        if (result(0) !== {1'b1, 1'b1, 8'h7F}) begin
            errors++;
            $display("FAIL sub_80_01: res=%h required %h", result(0), {1'b1, 1'b1, 8'h7F});
        end
        quiesce();
        issue(8'h00, 8'h01, 1'b1, 1'b0);
        wait_done(0);
        vectors++;
        if (result(0) !== {1'b0, 1'b0, 8'hFF}) begin
            errors++;
            $display("FAIL sub_00_01: res=%h required %h", result(0), {1'b0, 1'b0, 8'hFF});
        end
        quiesce();
    endtask

    task automatic test_d4();
        issue(8'h7F, 8'h01, 1'b0, 1'b0);
        for (int k = 0; k <= 2; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            vectors++;
            if ({busy_v[2], done_v[2]} !== {(k <= 1), (k == 2)}) begin
                errors++;
                $display("FAIL d4_latency k=%0d: busy/done=%b%b required %b%b",
                         k, busy_v[2], done_v[2], (k <= 1), (k == 2));
            end
        end
        vectors++;
        if (result(2) !== {1'b0, 1'b1, 8'h80}) begin
            errors++;
            $display("FAIL d4_7f_01: res=%h required %h", result(2), {1'b0, 1'b1, 8'h80});
        end
        quiesce();
        issue(8'h0F, 8'hF0, 1'b0, 1'b1);
        wait_done(2);
        vectors++;
        if (result(2) !== {1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL d4_0f_f0_c1: res=%h required %h", result(2), {1'b1, 1'b0, 8'h00});
        end
        quiesce();
    endtask

    task automatic test_start_ignored();
        int         ndone [2];
        logic [9:0] res   [2];
        ndone[0] = 0; ndone[1] = 0;
        res[0] = '0; res[1] = '0;
        issue(8'h3C, 8'h15, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        a = 8'h00; b = 8'h00; sub = 1'b1; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 14; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (done_v[i]) begin
                    ndone[i]++;
                    res[i] = result(i);
                end
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (ndone[i] !== 1) begin
                errors++;
                $display("FAIL ignore_pulses[%0d]: done pulses=%0d required 1", i, ndone[i]);
            end
            vectors++;
            if (res[i] !== model(8'h3C, 8'h15, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL ignore_result[%0d]: res=%h required %h",
                         i, res[i], model(8'h3C, 8'h15, 1'b0, 1'b0));
            end
        end
        quiesce();
    endtask

    task automatic test_reset_mid();
        int ndone;
        issue(8'hC3, 8'h5A, 1'b0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({busy_v[i], done_v[i], result(i)} !== 12'h000) begin
                errors++;
                $display("FAIL reset_mid[%0d]: busy=%b done=%b res=%h required all 0",
                         i, busy_v[i], done_v[i], result(i));
            end
        end
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (done_v[0]) ndone++;
            @(posedge clk); #1;
        end
        vectors++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL reset_mid_nodone: done pulses=%0d required 0", ndone);
        end
        issue(8'h12, 8'h34, 1'b1, 1'b0);
        wait_done(0);
        vectors++;
        if (result(0) !== model(8'h12, 8'h34, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL reset_mid_fresh: res=%h required %h",
                     result(0), model(8'h12, 8'h34, 1'b1, 1'b0));
        end
        quiesce();
    endtask

    task automatic test_back_to_back();
        int ndone;
        int t [3];
        t[0] = 0; t[1] = 0; t[2] = 0;
        ndone = 0;
        a = 8'hA7; b = 8'h3B; sub = 1'b0; cin = 1'b1; start = 1'b1;
        for (int k = 0; k < 26; k++) begin
            @(posedge clk); #1;
            if (done_v[1]) begin
                if (ndone < 3) t[ndone] = k;
                ndone++;
                vectors++;
                if (result(1) !== model(8'hA7, 8'h3B, 1'b0, 1'b1)) begin
                    errors++;
                    $display("FAIL b2b_result: res=%h required %h",
                             result(1), model(8'hA7, 8'h3B, 1'b0, 1'b1));
                end
                if (ndone >= 3) start = 1'b0;
            end
        end
        start = 1'b0;
        vectors++;
        if (ndone !== 3) begin
            errors++;
            $display("FAIL b2b_count: done pulses=%0d required 3", ndone);
        end
        vectors++;
        if ({t[0], t[1] - t[0], t[2] - t[1]} !== {32'd4, 32'd5, 32'd5}) begin
            errors++;
            $display("FAIL b2b_spacing: first=%0d gaps=%0d,%0d required 4 5,5",
                     t[0], t[1] - t[0], t[2] - t[1]);
        end
        quiesce();
    endtask

    task automatic test_random();
        logic [7:0] x, y;
        logic       s, c;
        bit         seen [4];
        for (int n = 0; n < 1000; n++) begin
            quiesce();
            x = 8'($urandom); y = 8'($urandom);
            s = 1'($urandom); c = 1'($urandom);
            for (int i = 0; i < 4; i++) seen[i] = 0;
            issue(x, y, s, c);
            a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
            for (int k = 0; k < 12; k++) begin
                for (int i = 0; i < 4; i++) begin
                    if (busy_v[i] && done_v[i]) begin
                        vectors++; errors++;
                        $display("FAIL rand_busy_done[%0d]: busy=1 done=1 required not both", i);
                    end
                    if (done_v[i] && !seen[i]) begin
                        seen[i] = 1;
                        vectors++;
                        if (result(i) !== model(x, y, s, c)) begin
                            errors++;
                            $display("FAIL rand[%0d] a=%h b=%h sub=%b cin=%b: res=%h required %h",
                                     i, x, y, s, c, result(i), model(x, y, s, c));
                        end
                    end
                end
                if (seen[0] && seen[1] && seen[2] && seen[3]) break;
                @(posedge clk); #1;
            end
            for (int i = 0; i < 4; i++) begin
                if (!seen[i]) begin
                    vectors++; errors++;
                    $display("FAIL rand_timeout[%0d]: done=0 required 1 within 12 cycles", i);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_sub_d1();
        test_d4();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
